// File: rtl/fft_twiddle_gen_3x.sv
// fft_twiddle_gen_3x: quarter-wave ROM twiddle source sharing one read port over three fast slots per base cycle.
module fft_twiddle_gen_3x #(
  parameter int TWIDDLE_WIDTH = 10,
  parameter int FFT_N         = 1024,
  parameter int NLOG2         = 10,
  parameter int STAGE_N       = 1024,
  parameter int STAGE_NLOG2   = 10
) (
  input  logic                            clk_3x_i,
  input  logic                            rst_n,
  input  logic        [NLOG2-1:0]         ctr_i,
  output logic        [NLOG2-1:0]         ctr_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_re_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_im_o
);
  localparam int TW = TWIDDLE_WIDTH;
  // a stage can never be longer than the transform it belongs to
  localparam int S  = (STAGE_NLOG2 < $clog2(FFT_N)) ? STAGE_NLOG2 : $clog2(FFT_N);
  localparam int Q  = (1 << S) >> 2;
  localparam int QL = S - 2;
  localparam int AW = $clog2(Q + 1);

  function automatic int crom(int a);
    real v;
    v = $cos(6.283185307179586 * real'(a) / real'(STAGE_N)) * real'(2 ** (TW - 1) - 1);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  logic signed [TW-1:0] rom [0:Q];
  for (genvar a = 0; a <= Q; a++) begin : g_rom
    localparam logic signed [TW-1:0] CV = TW'(crom(a));
    assign rom[a] = CV;
  end

  logic        [1:0]       slot_q, slot_d, quad_q, quad_d, i, qp, quad;
  logic        [NLOG2-1:0] ctr_q, ctr_d, ctr_out_q, ctr_out_d;
  logic        [AW-1:0]    r_q, r_d, addr;
  logic        [S-1:0]     m, j, e;
  logic signed [TW-1:0]    rd_q, rd_d, a_q, a_d, w_re_q, w_re_d, w_im_q, w_im_d, re_sel, im_sel;

  always_comb begin
    m         = ctr_i[S-1:0];
    i         = m[S-1 -: 2];
    j         = m & S'(Q - 1);
    qp        = {i[0], i[1]};
    e         = S'(qp) * j;
    quad      = 2'(e >> QL);
    slot_d    = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
    ctr_d     = (slot_q == 2'd0) ? ctr_i : ctr_q;
    quad_d    = (slot_q == 2'd0) ? quad : quad_q;
    r_d       = (slot_q == 2'd0) ? AW'(e & S'(Q - 1)) : r_q;
    addr      = (slot_q == 2'd0) ? AW'(e & S'(Q - 1)) : AW'(Q) - r_q;
    rd_d      = rom[addr];
    a_d       = (slot_q == 2'd1) ? rd_q : a_q;
    // quad 3 cannot occur; it falls through to the quad 0 mapping
    re_sel    = (quad_q == 2'd1) ? -rd_q : (quad_q == 2'd2) ? -a_q : a_q;
    im_sel    = (quad_q == 2'd1) ? -a_q : (quad_q == 2'd2) ? rd_q : -rd_q;
    w_re_d    = (slot_q == 2'd2) ? re_sel : w_re_q;
    w_im_d    = (slot_q == 2'd2) ? im_sel : w_im_q;
    ctr_out_d = (slot_q == 2'd2) ? ctr_q : ctr_out_q;
  end

  always_ff @(posedge clk_3x_i) begin
    if (!rst_n) begin
      slot_q    <= '0;
      ctr_q     <= '0;
      quad_q    <= '0;
      r_q       <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      w_re_q    <= '0;
      w_im_q    <= '0;
      ctr_out_q <= '0;
    end else begin
      slot_q    <= slot_d;
      ctr_q     <= ctr_d;
      quad_q    <= quad_d;
      r_q       <= r_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      w_re_q    <= w_re_d;
      w_im_q    <= w_im_d;
      ctr_out_q <= ctr_out_d;
    end
  end

  assign ctr_o  = ctr_out_q;
  assign w_re_o = w_re_q;
  assign w_im_o = w_im_q;
endmodule

// File: tb/tb_fft_twiddle_gen_3x.sv
// tb_fft_twiddle_gen_3x: directed checks of the 3x-clock twiddle generator with a 16-point stage.
module tb_fft_twiddle_gen_3x;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic        [9:0] ctr_i = '0;
  logic        [9:0] ctr_o;
  logic signed [9:0] w_re, w_im;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fft_twiddle_gen_3x #(
    .TWIDDLE_WIDTH(10), .FFT_N(1024), .NLOG2(10), .STAGE_N(16), .STAGE_NLOG2(4)
  ) dut (
    .clk_3x_i(clk), .rst_n(rst_n), .ctr_i(ctr_i), .ctr_o(ctr_o), .w_re_o(w_re), .w_im_o(w_im)
  );

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int rnd(real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    ctr_i = 10'd0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (w_re !== 10'sd0 || w_im !== 10'sd0 || ctr_o !== 10'd0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got re=%0d im=%0d ctr=%0h, want 0 0 0", k, w_re, w_im, ctr_o);
      end
    end
    rst_n = 1'b1;
    step(2);
    checks++;
    if (w_re !== 10'sd0 || w_im !== 10'sd0 || ctr_o !== 10'd0) begin
      fails++;
      $display("FAIL reset_latency: got re=%0d im=%0d ctr=%0h before third edge, want 0 0 0", w_re, w_im, ctr_o);
    end
    step();
    checks++;
    if (int'(w_re) !== 511 || int'(w_im) !== 0 || ctr_o !== 10'd0) begin
      fails++;
      $display("FAIL reset_first: got re=%0d im=%0d ctr=%0h, want 511 0 0", w_re, w_im, ctr_o);
    end
  endtask

  task automatic test_vectors();
    int tc [3] = '{5, 15, 9};
    int tre[3] = '{361, -472, 472};
    int tim[3] = '{-361, 196, -196};
    for (int k = 0; k < 3; k++) begin
      ctr_i = 10'(tc[k]);
      step(3);
      checks++;
      if (int'(w_re) !== tre[k] || int'(w_im) !== tim[k] || ctr_o !== 10'(tc[k])) begin
        fails++;
        $display("FAIL vector_ctr%0d: got re=%0d im=%0d ctr=%0h, want %0d %0d %0h",
                 tc[k], w_re, w_im, ctr_o, tre[k], tim[k], tc[k]);
      end
    end
  endtask

  task automatic test_sweep();
    for (int c = 0; c < 16; c++) begin
      int ii, jj, qq, ee, ere, eim;
      real th;
      ii  = c >> 2;
      jj  = c & 3;
      qq  = ((ii & 1) << 1) | (ii >> 1);
      ee  = qq * jj;
      th  = 6.283185307179586 * real'(ee) / 16.0;
      ere = rnd($cos(th) * 511.0);
      eim = rnd(-$sin(th) * 511.0);
      ctr_i = 10'(c);
      step(3);
      checks++;
      if (int'(w_re) !== ere || int'(w_im) !== eim || ctr_o !== 10'(c)) begin
        fails++;
        $display("FAIL sweep_ctr%0d: got re=%0d im=%0d ctr=%0h, want %0d %0d %0h",
                 c, w_re, w_im, ctr_o, ere, eim, c);
      end
    end
  endtask

  task automatic test_upper_bits();
    ctr_i = 10'h3F5;
    step(3);
    checks++;
    if (int'(w_re) !== 361 || int'(w_im) !== -361 || ctr_o !== 10'h3F5) begin
      fails++;
      $display("FAIL upper_bits: got re=%0d im=%0d ctr=%0h, want 361 -361 3f5", w_re, w_im, ctr_o);
    end
    ctr_i = 10'd0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (int'(w_re) !== 361 || int'(w_im) !== -361 || ctr_o !== 10'h3F5) begin
        fails++;
        $display("FAIL hold_slot%0d: got re=%0d im=%0d ctr=%0h, want 361 -361 3f5", k, w_re, w_im, ctr_o);
      end
    end
    step();
    checks++;
    if (int'(w_re) !== 511 || int'(w_im) !== 0 || ctr_o !== 10'd0) begin
      fails++;
      $display("FAIL wrap_to_zero: got re=%0d im=%0d ctr=%0h, want 511 0 0", w_re, w_im, ctr_o);
    end
  endtask

  task automatic test_midframe_reset();
    ctr_i = 10'd15;
    step();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (w_re !== 10'sd0 || w_im !== 10'sd0 || ctr_o !== 10'd0) begin
      fails++;
      $display("FAIL midframe_abort: got re=%0d im=%0d ctr=%0h, want 0 0 0", w_re, w_im, ctr_o);
    end
    rst_n = 1'b1;
    step(2);
    checks++;
    if (w_re !== 10'sd0 || w_im !== 10'sd0 || ctr_o !== 10'd0) begin
      fails++;
      $display("FAIL restart_latency: got re=%0d im=%0d ctr=%0h early, want 0 0 0", w_re, w_im, ctr_o);
    end
    step();
    checks++;
    if (int'(w_re) !== -472 || int'(w_im) !== 196 || ctr_o !== 10'd15) begin
      fails++;
      $display("FAIL restart_first: got re=%0d im=%0d ctr=%0h, want -472 196 f", w_re, w_im, ctr_o);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_sweep();
    test_upper_bits();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
